any1_writeback: RTL

- Returns results from the functional units into the reorder buffer. This is the return path opposite the instruction scheduler, which selects ROB entries for execution.
- Accepts completed results from NSRC functional-unit sources using a valid/ready handshake per source.
- Buffers results in one small FIFO per source, then applies round-robin arbitration.
- Issues one registered writeback per cycle. The writeback marks the ROB entry done/cmt and broadcasts the tag so waiting operands can wake up.

---
 rtl/any1_pkg.sv | 24 ++
 rtl/any1_wb_fifo.sv | 68 ++++++
 rtl/any1_writeback.sv | 132 +++++++++++++
 3 files changed

// File: rtl/any1_pkg.sv
// any1_pkg
//   Shared types and constants for the result writeback path.
//   - sWritebackEntry : one completed result (ROB index, value, exception cause)
//   - NULL_RID        : ROB index that marks a result to be dropped
//   - WB_ALU..WB_BR   : source numbers carried on the writeback bus
package any1_pkg;

    // Result width carried in the writeback entry; the top-level WID must match.
    localparam int WB_WID = 64;

    localparam logic [5:0] NULL_RID = 6'd63;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_FPU = 2'd1;
    localparam logic [1:0] WB_MEM = 2'd2;
    localparam logic [1:0] WB_BR  = 2'd3;

    typedef struct packed {
        logic [5:0]        rid;
        logic [WB_WID-1:0] res;
        logic [7:0]        exc;
    } sWritebackEntry;

endpackage

// File: rtl/any1_wb_fifo.sv
// any1_wb_fifo
//   Small synchronous FIFO of writeback entries, one per result source.
//   Ports:
//     clk, rst      clock, synchronous active-high reset (empties the FIFO)
//     clr           synchronous clear (pipeline flush); overrides push/pop
//     push, din     write one entry; the caller only pushes when not full
//     pop, dout     remove the head entry; dout always shows the head
//     full, empty   occupancy flags from the registered count
//     count         number of stored entries (0..DEPTH)
module any1_wb_fifo
    import any1_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  sWritebackEntry             din,
    input  logic                       pop,
    output sWritebackEntry             dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    sWritebackEntry mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  cnt;

    // Guard against misuse: never write into a full FIFO or read an empty one.
    logic do_push;
    logic do_pop;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;   // power-of-two depth: wraps naturally
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/any1_writeback.sv
// any1_writeback
//   Return path from the functional units into the reorder buffer. Each
//   source pushes completed results into its own FIFO; a round-robin arbiter
//   picks one FIFO head per cycle and issues a registered writeback that
//   marks the ROB entry done and broadcasts the tag for operand wakeup.
//
//   Handshake: a source transfers a result at a clock edge where
//   src_v_i[s] & src_rdy_o[s]. src_rdy_o[s] depends only on the registered
//   FIFO occupancy, never on this cycle's pop, so a full FIFO stays not-ready
//   even in a cycle where it is being drained.
//
//   Ports:
//     clk_i, rst_i   clock, synchronous active-high reset
//     flush_i        discard every buffered result; suppress this edge's pushes/writeback
//     src_v_i/src_rdy_o            per-source valid/ready
//     src_rid_i/src_res_i/src_exc_i per-source ROB index, result, exception cause
//     wb_v_o         one-cycle writeback pulse
//     wb_rid_o/wb_res_o/wb_exc_o/wb_src_o  writeback fields (held when idle)
//     busy_o         any result buffered or a writeback in flight
module any1_writeback
    import any1_pkg::*;
#(
    parameter int NSRC   = 4,
    parameter int FDEPTH = 2,
    parameter int WID    = WB_WID
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic [NSRC-1:0]     src_v_i,
    output logic [NSRC-1:0]     src_rdy_o,
    input  logic [6*NSRC-1:0]   src_rid_i,
    input  logic [WID*NSRC-1:0] src_res_i,
    input  logic [8*NSRC-1:0]   src_exc_i,
    output logic                wb_v_o,
    output logic [5:0]          wb_rid_o,
    output logic [WID-1:0]      wb_res_o,
    output logic [7:0]          wb_exc_o,
    output logic [1:0]          wb_src_o,
    output logic                busy_o
);

    localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int CW = $clog2(FDEPTH) + 1;

    sWritebackEntry  in_ent  [NSRC];
    sWritebackEntry  head    [NSRC];
    logic [CW-1:0]   cnt     [NSRC];
    logic [NSRC-1:0] push;
    logic [NSRC-1:0] pop;
    logic [NSRC-1:0] full;
    logic [NSRC-1:0] empty;

    logic [SW-1:0]   last_grant;
    logic            grant_v;
    logic [SW-1:0]   grant_idx;

    // Per-source FIFOs. A null-tag result completes its handshake but is
    // never stored, so it can never produce a writeback.
    for (genvar s = 0; s < NSRC; s++) begin : g_src
        assign in_ent[s] = '{rid: src_rid_i[6*s +: 6],
                             res: src_res_i[WID*s +: WID],
                             exc: src_exc_i[8*s +: 8]};

        assign src_rdy_o[s] = ~full[s];
        assign push[s] = src_v_i[s] & src_rdy_o[s] & ~flush_i
                       & (src_rid_i[6*s +: 6] != NULL_RID);
        assign pop[s]  = grant_v & (grant_idx == SW'(s)) & ~flush_i;

        any1_wb_fifo #(
            .DEPTH (FDEPTH)
        ) u_fifo (
            .clk   (clk_i),
            .rst   (rst_i),
            .clr   (flush_i),
            .push  (push[s]),
            .din   (in_ent[s]),
            .pop   (pop[s]),
            .dout  (head[s]),
            .full  (full[s]),
            .empty (empty[s]),
            .count (cnt[s])
        );
    end

    // Round-robin: scan starts one past the last winner; first non-empty wins.
    always_comb begin
        logic [SW-1:0] cand;
        grant_v   = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 1; i <= NSRC; i++) begin
            cand = SW'((int'(last_grant) + i) % NSRC);
            if (!grant_v && !empty[cand]) begin
                grant_v   = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Registered writeback. Fields hold their last value when idle; flush
    // kills the pulse but keeps the round-robin pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant <= '0;
            wb_v_o     <= 1'b0;
            wb_rid_o   <= NULL_RID;
            wb_res_o   <= '0;
            wb_exc_o   <= '0;
            wb_src_o   <= '0;
        end else if (flush_i) begin
            wb_v_o     <= 1'b0;
        end else if (grant_v) begin
            last_grant <= grant_idx;
            wb_v_o     <= 1'b1;
            wb_rid_o   <= head[grant_idx].rid;
            wb_res_o   <= head[grant_idx].res;
            wb_exc_o   <= head[grant_idx].exc;
            wb_src_o   <= 2'(grant_idx);
        end else begin
            wb_v_o     <= 1'b0;
        end
    end

    always_comb begin
        busy_o = wb_v_o;
        for (int s = 0; s < NSRC; s++) begin
            if (cnt[s] != '0) busy_o = 1'b1;
        end
    end

endmodule
